// File: rtl/substitute_key_pkg.sv
// Shared types, key-array dimensions and the AES forward S-box table (FIPS-197)
// used by substitute_key and aes_sbox.
package substitute_key_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;

  typedef logic [7:0] byte_t;
  typedef byte_t [KEY_ROWS-1:0][KEY_COLS-1:0] key_t;

  // Indexed by the input byte; entry N is the forward substitution of N.
  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic byte_t sbox_lookup(input byte_t b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/substitute_key_aes_sbox.sv
// aes_sbox: purely combinational single-byte AES forward substitution.
module aes_sbox
  import substitute_key_pkg::*;
(
  input  byte_t din,
  output byte_t dout
);

  assign dout = sbox_lookup(din);

endmodule

// File: rtl/substitute_key.sv
// substitute_key: byte-wise AES S-box over a 4x4 key array, one registered stage.
// Optional pass-through input 'bypass' is present when SUBSTITUTE_KEY_BYPASS_EN is defined.
module substitute_key
  import substitute_key_pkg::*;
#(
  parameter int ROWS = KEY_ROWS,
  parameter int COLS = KEY_COLS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
`ifdef SUBSTITUTE_KEY_BYPASS_EN
  input  logic                         bypass,
`endif
  input  byte_t [ROWS-1:0][COLS-1:0]   subkeyin,
  output logic                         out_valid,
  output byte_t [ROWS-1:0][COLS-1:0]   subkeyout
);

  byte_t [ROWS-1:0][COLS-1:0] subbed;
  byte_t [ROWS-1:0][COLS-1:0] next_key;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      aes_sbox u_sbox (
        .din  (subkeyin[r][c]),
        .dout (subbed[r][c])
      );
    end
  end

  always_comb begin
    next_key = subbed;
`ifdef SUBSTITUTE_KEY_BYPASS_EN
    if (bypass) begin
      next_key = subkeyin;
    end
`endif
  end

  // Output data only moves on a valid input so it holds across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      subkeyout <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        subkeyout <= next_key;
      end
    end
  end

endmodule

// File: tb/tb_substitute_key.sv
// Self-checking bench for substitute_key; reference S-box is derived from GF(2^8)
// inversion plus the affine transform. Define SUBSTITUTE_KEY_BYPASS_EN to cover bypass.
module tb_substitute_key;
  import substitute_key_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  in_valid;
  logic  bypass;
  logic  out_valid;
  key_t  subkeyin;
  key_t  subkeyout;

  byte_t model_sbox [256];
  key_t  exp_key;
  logic  exp_valid;
  int    assertions = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  substitute_key #(.ROWS(4), .COLS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
`ifdef SUBSTITUTE_KEY_BYPASS_EN
    .bypass    (bypass),
`endif
    .subkeyin  (subkeyin),
    .out_valid (out_valid),
    .subkeyout (subkeyout)
  );

  function automatic byte_t gmul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t x;
    byte_t y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic byte_t affine(input byte_t b);
    byte_t s;
    s = b ^ 8'h63;
    for (int n = 1; n <= 4; n++) s = s ^ ((b << n) | (b >> (8 - n)));
    return s;
  endfunction

  task automatic buildModel();
    byte_t inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (gmul(byte_t'(v), byte_t'(j)) == 8'h01) inv = byte_t'(j);
      model_sbox[v] = affine(inv);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
    assertions++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Drive one cycle, advance the model on the edge, then check just after it.
  task automatic applyStimulus(input key_t key, input logic valid, input logic rst_in, input logic byp);
    logic byp_eff;
    subkeyin = key;
    in_valid = valid;
    rst      = rst_in;
    bypass   = byp;
`ifdef SUBSTITUTE_KEY_BYPASS_EN
    byp_eff = byp;
`else
    byp_eff = 1'b0;
`endif
    @(posedge clk);
    if (rst_in) begin
      exp_valid = 1'b0;
      exp_key   = '0;
    end else begin
      exp_valid = valid;
      if (valid)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            exp_key[r][c] = byp_eff ? key[r][c] : model_sbox[key[r][c]];
    end
    #1;
    checkOutput("out_valid", 128'(out_valid), 128'(exp_valid));
    checkOutput("subkeyout", subkeyout, exp_key);
  endtask

  function automatic key_t randomKey();
    key_t k;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        k[r][c] = byte_t'($urandom);
    return k;
  endfunction

  initial begin
    key_t k;
    logic byp;
    buildModel();
    exp_valid = 1'b0;
    exp_key   = '0;

    applyStimulus(randomKey(), 1'b1, 1'b1, 1'b0);
    applyStimulus(randomKey(), 1'b0, 1'b1, 1'b0);
    checkOutput("reset_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_key", subkeyout, 128'(0));

    k = randomKey();
    k[3][3] = 8'h12;
    k[2][2] = 8'h7a;
    k[1][1] = 8'h0d;
    k[0][0] = 8'h58;
    applyStimulus(k, 1'b1, 1'b0, 1'b0);
    checkOutput("vec_33", 128'(subkeyout[3][3]), 128'(8'hc9));
    checkOutput("vec_22", 128'(subkeyout[2][2]), 128'(8'hda));
    checkOutput("vec_11", 128'(subkeyout[1][1]), 128'(8'hd7));
    checkOutput("vec_00", 128'(subkeyout[0][0]), 128'(8'h6a));
    checkOutput("vec_valid", 128'(out_valid), 128'(1));

    applyStimulus({16{8'h00}}, 1'b1, 1'b0, 1'b0);
    checkOutput("all00", subkeyout, {16{8'h63}});
    applyStimulus({16{8'hff}}, 1'b1, 1'b0, 1'b0);
    checkOutput("allff", subkeyout, {16{8'h16}});

    applyStimulus(randomKey(), 1'b0, 1'b0, 1'b0);
    checkOutput("hold_key", subkeyout, {16{8'h16}});

    applyStimulus({16{8'h12}}, 1'b1, 1'b1, 1'b0);
    checkOutput("rst_prio_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_prio_key", subkeyout, 128'(0));
    applyStimulus({16{8'h12}}, 1'b1, 1'b0, 1'b0);
    checkOutput("post_rst", subkeyout, {16{8'hc9}});

`ifdef SUBSTITUTE_KEY_BYPASS_EN
    k = randomKey();
    k[0][0] = 8'h58;
    applyStimulus(k, 1'b1, 1'b0, 1'b1);
    checkOutput("bypass_00", 128'(subkeyout[0][0]), 128'(8'h58));
    checkOutput("bypass_key", subkeyout, k);
`endif

    // Each position walks a different permutation of all 256 values.
    for (int v = 0; v < 256; v++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          k[r][c] = byte_t'(v) ^ byte_t'((r * 4 + c) * 37);
      applyStimulus(k, 1'b1, 1'b0, 1'b0);
    end

    for (int n = 0; n < 300; n++) begin
`ifdef SUBSTITUTE_KEY_BYPASS_EN
      byp = ($urandom_range(0, 3) == 0);
`else
      byp = 1'b0;
`endif
      applyStimulus(randomKey(), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 19) == 0), byp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/substitute_key.md
SUBSTITUTE_KEY -- requirements
Module: substitute_key

Interface
REQ-001 Parameter ROWS, default 4: number of byte rows in the key array; only 4 is supported.
REQ-002 Parameter COLS, default 4: number of byte columns in the key array; only 4 is supported.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: subkeyin holds a key array to be substituted this cycle.
REQ-006 Port subkeyin, input, ROWS x COLS array of 8-bit bytes, indexed [row][col]: key bytes to be substituted.
REQ-007 Port out_valid, output, 1 bit: subkeyout holds a result.
REQ-008 Port subkeyout, output, ROWS x COLS array of 8-bit bytes, indexed [row][col]: substituted key bytes.
REQ-009 Port bypass, input, 1 bit: pass key bytes through unsubstituted; present only when SUBSTITUTE_KEY_BYPASS_EN is defined.

Function
REQ-010 Each output byte SHALL be the standard AES forward S-box (FIPS-197) of the input byte at the same [row][col].
- Results are element-wise; no byte depends on any other byte.
REQ-011 Latency SHALL be exactly 1 cycle: a key sampled with in_valid=1 at edge N appears on subkeyout with out_valid=1 after edge N.
REQ-012 out_valid SHALL equal in_valid delayed by one cycle.
REQ-013 Throughput SHALL be one key array per cycle with no stall or back-pressure; back-to-back valid inputs produce back-to-back outputs.
REQ-014 When in_valid=0, subkeyout SHALL hold its previous value, and out_valid SHALL be 0 on the following cycle.
REQ-015 The S-box SHALL be fully combinational between the input and the output register.
- All 256 entries are exact.
- No X is produced for any defined input.

Reset
REQ-016 When rst=1 at a rising edge, out_valid SHALL become 0 and every subkeyout byte SHALL become 8'h00.
REQ-017 rst SHALL take priority over in_valid on the same edge: a key presented during reset is discarded.
REQ-018 On the first edge after rst deasserts, a valid input SHALL be accepted normally, with its result on the next cycle.

Configuration
REQ-019 With macro SUBSTITUTE_KEY_BYPASS_EN defined, the bypass port SHALL exist.
- bypass=1, sampled with the key, causes subkeyout to equal subkeyin with the same 1-cycle latency and out_valid behaviour.
REQ-020 Without SUBSTITUTE_KEY_BYPASS_EN, the bypass port SHALL be absent and substitution always applies.

Structure
REQ-021 A shared package SHALL hold:
- the byte typedef;
- the 4x4 key-array typedef;
- ROWS/COLS constants;
- the 256-entry AES S-box constant table.
REQ-022 One sub-module, aes_sbox, SHALL map one byte to one byte combinationally; substitute_key SHALL instantiate it 16 times, once per [row][col].

Verification
REQ-023 Apply rst=1 for 2 cycles -> out_valid=0 and every subkeyout byte = 8'h00.
REQ-024 Set subkeyin[3][3]=8'h12, [2][2]=8'h7a, [1][1]=8'h0d, [0][0]=8'h58 with in_valid=1 -> one cycle later subkeyout[3][3]=8'hc9, [2][2]=8'hda, [1][1]=8'hd7, [0][0]=8'h6a and out_valid=1.
REQ-025 Fill every byte with 8'h00, then with 8'hff, on consecutive valid cycles -> consecutive outputs are all 8'h63, then all 8'h16.
REQ-026 Sweep each byte position through all 256 values -> every output matches the FIPS-197 table with no cross-position interference.
REQ-027 Assert rst in the same cycle as in_valid=1 with data 8'h12 -> next cycle out_valid=0 and subkeyout is all 8'h00.
REQ-028 With SUBSTITUTE_KEY_BYPASS_EN defined, apply bypass=1 and subkeyin[0][0]=8'h58 -> one cycle later subkeyout[0][0]=8'h58.
